// File: rtl/db_fsm_if.sv
// Switch/debounce signal bundle between the sample ticker, the raw switch
// and the debounce FSM.
interface db_fsm_if;
    logic tick;
    logic sw;
    logic db_level;
    logic db_rise;
    logic db_fall;

    modport master (
        output tick,
        output sw,
        input  db_level,
        input  db_rise,
        input  db_fall
    );

    modport slave (
        input  tick,
        input  sw,
        output db_level,
        output db_rise,
        output db_fall
    );
endinterface

// File: rtl/db_fsm.sv
// Debounce FSM: synchronizes a raw switch and accepts a level change only after
// it has stayed stable across N_TICKS sample ticks; emits clean level plus edge strobes.
module db_fsm #(
    parameter int N_TICKS = 3,
    parameter int CW      = 4
) (
    input logic     clk,
    input logic     reset,
    db_fsm_if.slave bus
);

    typedef enum logic [1:0] {
        ZERO  = 2'b00,
        WAIT1 = 2'b01,
        ONE   = 2'b10,
        WAIT0 = 2'b11
    } state_t;

    localparam logic [CW-1:0] CNT_LOAD = CW'(N_TICKS);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_ZERO = CW'(0);

    logic          sw_m;
    logic          sw_s;
    state_t        state_r;
    state_t        state_next_s;
    logic [CW-1:0] cnt_r;
    logic [CW-1:0] cnt_next_s;
    logic          level_r;
    logic          level_next_s;
    logic          rise_r;
    logic          rise_next_s;
    logic          fall_r;
    logic          fall_next_s;

    // Two-flop synchronizer for the asynchronous switch input.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sw_m <= 1'b0;
            sw_s <= 1'b0;
        end else begin
            sw_m <= bus.sw;
            sw_s <= sw_m;
        end
    end

    // State, counter and registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= ZERO;
            cnt_r   <= CNT_ZERO;
            level_r <= 1'b0;
            rise_r  <= 1'b0;
            fall_r  <= 1'b0;
        end else begin
            state_r <= state_next_s;
            cnt_r   <= cnt_next_s;
            level_r <= level_next_s;
            rise_r  <= rise_next_s;
            fall_r  <= fall_next_s;
        end
    end

    // Next-state logic; a mismatch always beats a tick in the same cycle.
    always_comb begin
        state_next_s = state_r;
        cnt_next_s   = cnt_r;
        level_next_s = level_r;
        rise_next_s  = 1'b0;
        fall_next_s  = 1'b0;
        case (state_r)
            ZERO: begin
                level_next_s = 1'b0;
                if (sw_s) begin
                    state_next_s = WAIT1;
                    cnt_next_s   = CNT_LOAD;
                end else begin
                    state_next_s = ZERO;
                end
            end
            WAIT1: begin
                level_next_s = 1'b0;
                if (!sw_s) begin
                    state_next_s = ZERO;
                end else if (bus.tick && (cnt_r == CNT_ONE)) begin
                    state_next_s = ONE;
                    level_next_s = 1'b1;
                    rise_next_s  = 1'b1;
                end else if (bus.tick) begin
                    cnt_next_s = cnt_r - CNT_ONE;
                end else begin
                    state_next_s = WAIT1;
                end
            end
            ONE: begin
                level_next_s = 1'b1;
                if (!sw_s) begin
                    state_next_s = WAIT0;
                    cnt_next_s   = CNT_LOAD;
                end else begin
                    state_next_s = ONE;
                end
            end
            WAIT0: begin
                level_next_s = 1'b1;
                if (sw_s) begin
                    state_next_s = ONE;
                end else if (bus.tick && (cnt_r == CNT_ONE)) begin
                    state_next_s = ZERO;
                    level_next_s = 1'b0;
                    fall_next_s  = 1'b1;
                end else if (bus.tick) begin
                    cnt_next_s = cnt_r - CNT_ONE;
                end else begin
                    state_next_s = WAIT0;
                end
            end
            default: begin
                state_next_s = ZERO;
                cnt_next_s   = CNT_ZERO;
                level_next_s = 1'b0;
            end
        endcase
    end

    assign bus.db_level = level_r;
    assign bus.db_rise  = rise_r;
    assign bus.db_fall  = fall_r;

endmodule
